// File: rtl/fp_add_subt_pkg.sv
// Shared constants and state encoding for the sequential single-precision adder/subtractor.
package fp_add_subt_pkg;

  localparam int W    = 32;
  localparam int EW   = 8;
  localparam int SW   = 23;
  localparam int BIAS = 127;

  // Internal mantissa: hidden bit, fraction, guard, round, sticky.
  localparam int MW   = SW + 4;
  localparam int SUMW = MW + 1;
  localparam int LZW  = 5;
  localparam int RW   = SW + 2;
  localparam int XW   = EW + 2;

  localparam int EXP_INF = 2 * BIAS + 1;

  localparam logic [W-1:0] QNAN = 32'h7FC0_0000;
  localparam logic [W-1:0] PINF = 32'h7F80_0000;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    DONE
  } state_t;

endpackage

// File: rtl/fp_add_subt_seq_lzc.sv
// Combinational leading-zero counter over the 28-bit raw sum; an all-zero input reports 28.
module fp_lzc
  import fp_add_subt_pkg::*;
(
  input  logic [SUMW-1:0] value,
  output logic [LZW-1:0]  count
);

  always_comb begin
    count = LZW'(SUMW);
    for (int i = 0; i < SUMW; i++) begin
      if (value[i]) count = LZW'(SUMW - 1 - i);
    end
  end

endmodule

// File: rtl/fp_add_subt_seq.sv
// Multi-cycle IEEE-754 single-precision add/subtract responder with a held result acknowledge.
// One operation in flight; denormal inputs are treated as zero and tiny results flush to zero.
module fp_add_subt_seq
  import fp_add_subt_pkg::*;
(
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         Begin_SUM,
  input  logic         ADD_SUBT,
  input  logic [W-1:0] Data_X,
  input  logic [W-1:0] Data_Y,
  output logic         ACK_ADD_SUBT,
  output logic [W-1:0] Data_Result,
  output logic         Overflow,
  output logic         Underflow
);

  localparam logic signed [XW-1:0] E_INF  = XW'(EXP_INF);
  localparam logic signed [XW-1:0] E_ZERO = '0;

  state_t state_q, state_d;

  logic [W-1:0]  x_q, x_d, y_q, y_d;
  logic          op_q, op_d;
  logic          sign_q, sign_d;
  logic          sub_q, sub_d;
  logic [EW-1:0] ea_q, ea_d, eb_q, eb_d;
  logic [MW-1:0] ma_q, ma_d, mb_q, mb_d;
  logic          spec_q, spec_d;
  logic [W-1:0]  spec_val_q, spec_val_d;
  logic [SUMW-1:0]       sum_q, sum_d;
  logic signed [XW-1:0]  exp_q, exp_d;
  logic [MW-1:0]         mant_q, mant_d;
  logic          ack_q, ack_d;
  logic [W-1:0]  result_q, result_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          sx, sy;
  logic [EW-1:0] ex, ey;
  logic [SW-1:0] fx, fy;
  logic          x_zero, y_zero, x_nan, y_nan, x_inf, y_inf;
  logic [MW-1:0] mx, my;
  logic          swap;
  logic          spec_hit;
  logic [W-1:0]  spec_word;

  assign sx = x_q[W-1];
  assign ex = x_q[W-2:SW];
  assign fx = x_q[SW-1:0];
  assign sy = y_q[W-1] ^ op_q;
  assign ey = y_q[W-2:SW];
  assign fy = y_q[SW-1:0];

  assign x_zero = (ex == '0);
  assign y_zero = (ey == '0);
  assign x_nan  = (&ex) & (|fx);
  assign y_nan  = (&ey) & (|fy);
  assign x_inf  = (&ex) & ~(|fx);
  assign y_inf  = (&ey) & ~(|fy);

  assign mx   = x_zero ? '0 : {1'b1, fx, 3'b000};
  assign my   = y_zero ? '0 : {1'b1, fy, 3'b000};
  assign swap = {ey, fy} > {ex, fx};

  assign spec_hit  = x_nan | y_nan | x_inf | y_inf;
  assign spec_word = (x_nan | y_nan | (x_inf & y_inf & (sx ^ sy))) ? QNAN :
                     x_inf ? (PINF | {sx, {(W-1){1'b0}}}) :
                             (PINF | {sy, {(W-1){1'b0}}});

  // Alignment: bits shifted past the sticky position collapse into it.
  logic [EW-1:0] align_dist;
  logic [MW-1:0] b_shifted, b_aligned;
  logic          b_lost;

  assign align_dist = ea_q - eb_q;
  assign b_shifted  = mb_q >> align_dist;
  assign b_lost     = |(mb_q & ~({MW{1'b1}} << align_dist));
  assign b_aligned  = b_shifted | {{(MW-1){1'b0}}, b_lost};

  logic [SUMW-1:0] sum_w;
  assign sum_w = sub_q ? ({1'b0, ma_q} - {1'b0, mb_q}) : ({1'b0, ma_q} + {1'b0, mb_q});

  // Normalising so the leading one lands at bit 27 covers carry-out and cancellation alike.
  logic [LZW-1:0]       lz;
  logic [SUMW-1:0]      norm_shift;
  logic [MW-1:0]        norm_mant;
  logic signed [XW-1:0] norm_exp;

  fp_lzc u_lzc (
    .value (sum_q),
    .count (lz)
  );

  assign norm_shift = sum_q << lz;
  assign norm_mant  = norm_shift[SUMW-1:1] | {{(MW-1){1'b0}}, norm_shift[0]};
  assign norm_exp   = exp_q + $signed(XW'(1)) - $signed(XW'(lz));

  logic                 rnd_inc;
  logic [RW-1:0]        rnd_sum;
  logic signed [XW-1:0] rnd_exp;
  logic                 rnd_zero;

  assign rnd_inc  = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
  assign rnd_sum  = {1'b0, mant_q[MW-1:3]} + RW'(rnd_inc);
  assign rnd_exp  = exp_q + $signed(XW'(rnd_sum[RW-1]));
  assign rnd_zero = ~(rnd_sum[RW-1] | rnd_sum[RW-2]);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    op_d       = op_q;
    sign_d     = sign_q;
    sub_d      = sub_q;
    ea_d       = ea_q;
    eb_d       = eb_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    sum_d      = sum_q;
    exp_d      = exp_q;
    mant_d     = mant_q;
    ack_d      = ack_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;

    case (state_q)
      IDLE: begin
        if (Begin_SUM) begin
          x_d     = Data_X;
          y_d     = Data_Y;
          op_d    = ADD_SUBT;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        sign_d     = swap ? sy : sx;
        ea_d       = swap ? ey : ex;
        eb_d       = swap ? ex : ey;
        ma_d       = swap ? my : mx;
        mb_d       = swap ? mx : my;
        sub_d      = sx ^ sy;
        spec_d     = spec_hit;
        spec_val_d = spec_word;
        state_d    = ALIGN;
      end
      ALIGN: begin
        mb_d    = b_aligned;
        state_d = ADD;
      end
      ADD: begin
        sum_d   = sum_w;
        exp_d   = $signed(XW'(ea_q));
        state_d = NORM;
      end
      NORM: begin
        mant_d  = norm_mant;
        exp_d   = norm_exp;
        state_d = ROUND;
      end
      ROUND: begin
        ack_d   = 1'b1;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        state_d = DONE;
        if (spec_q) begin
          result_d = spec_val_q;
        end else if (rnd_zero) begin
          result_d = '0;
        end else if (rnd_exp >= E_INF) begin
          result_d = PINF | {sign_q, {(W-1){1'b0}}};
          ovf_d    = 1'b1;
        end else if (rnd_exp <= E_ZERO) begin
          result_d = {sign_q, {(W-1){1'b0}}};
          unf_d    = 1'b1;
        end else begin
          result_d = {sign_q, rnd_exp[EW-1:0], rnd_sum[SW-1:0]};
        end
      end
      DONE: begin
        if (Begin_SUM) begin
          x_d     = Data_X;
          y_d     = Data_Y;
          op_d    = ADD_SUBT;
          ack_d   = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = UNPACK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      op_q       <= 1'b0;
      sign_q     <= 1'b0;
      sub_q      <= 1'b0;
      ea_q       <= '0;
      eb_q       <= '0;
      ma_q       <= '0;
      mb_q       <= '0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      sum_q      <= '0;
      exp_q      <= '0;
      mant_q     <= '0;
      ack_q      <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      op_q       <= op_d;
      sign_q     <= sign_d;
      sub_q      <= sub_d;
      ea_q       <= ea_d;
      eb_q       <= eb_d;
      ma_q       <= ma_d;
      mb_q       <= mb_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      sum_q      <= sum_d;
      exp_q      <= exp_d;
      mant_q     <= mant_d;
      ack_q      <= ack_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign ACK_ADD_SUBT = ack_q;
  assign Data_Result  = result_q;
  assign Overflow     = ovf_q;
  assign Underflow    = unf_q;

endmodule

// File: tb/tb_fp_add_subt_seq.sv
// Scoreboarded bench for fp_add_subt_seq: an exact-arithmetic reference model feeds a queue that
// a free-running monitor drains on every rising ACK_ADD_SUBT.
module tb_fp_add_subt_seq;

  logic        CLK;
  logic        RST_N;
  logic        Begin_SUM;
  logic        ADD_SUBT;
  logic [31:0] Data_X;
  logic [31:0] Data_Y;
  logic        ACK_ADD_SUBT;
  logic [31:0] Data_Result;
  logic        Overflow;
  logic        Underflow;

  int          vectors    = 0;
  int          miscompares = 0;
  logic [33:0] expQ[$];
  bit          ackPrev = 1'b0;

  fp_add_subt_seq dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .Begin_SUM    (Begin_SUM),
    .ADD_SUBT     (ADD_SUBT),
    .Data_X       (Data_X),
    .Data_Y       (Data_Y),
    .ACK_ADD_SUBT (ACK_ADD_SUBT),
    .Data_Result  (Data_Result),
    .Overflow     (Overflow),
    .Underflow    (Underflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: exact sum of the two values as wide integers, then round-to-nearest-even to 24
  // significant bits. Returns {Overflow, Underflow, result}.
  function automatic logic [33:0] refModel(input logic [31:0] x, input logic [31:0] y, input logic op);
    logic         sx, sy, sr, up;
    int           ex, ey, emin, p, sh, e;
    logic [299:0] mx, my, mag, q, rem, half;
    sx = x[31];
    sy = y[31] ^ op;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0)) return {2'b00, 32'h7FC00000};
    if (ex == 255 && ey == 255) return (sx != sy) ? {2'b00, 32'h7FC00000} : {2'b00, sx, 31'h7F800000};
    if (ex == 255) return {2'b00, sx, 31'h7F800000};
    if (ey == 255) return {2'b00, sy, 31'h7F800000};
    if (ex == 0 && ey == 0) return 34'd0;
    if (ex == 0) emin = ey;
    else if (ey == 0) emin = ex;
    else emin = (ex < ey) ? ex : ey;
    mx = (ex == 0) ? '0 : (300'({1'b1, x[22:0]}) << (ex - emin));
    my = (ey == 0) ? '0 : (300'({1'b1, y[22:0]}) << (ey - emin));
    if (sx == sy) begin
      mag = mx + my; sr = sx;
    end else if (mx >= my) begin
      mag = mx - my; sr = sx;
    end else begin
      mag = my - mx; sr = sy;
    end
    if (mag == 0) return 34'd0;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    if (p <= 23) begin
      q = mag << (23 - p);
      e = emin - (23 - p);
    end else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag & ((300'd1 << sh) - 300'd1);
      half = 300'd1 << (sh - 1);
      up   = (rem > half) || ((rem == half) && q[0]);
      q    = q + 300'(up);
      if (q[24]) begin
        q  = q >> 1;
        sh = sh + 1;
      end
      e = emin + sh;
    end
    if (e >= 255) return {1'b1, 1'b0, sr, 31'h7F800000};
    if (e <= 0)   return {1'b0, 1'b1, sr, 31'h00000000};
    return {2'b00, sr, 8'(e), q[22:0]};
  endfunction

  // Monitor: each new acknowledge retires the oldest expected response.
  always @(negedge CLK) begin
    logic [33:0] exp34;
    if (RST_N && ACK_ADD_SUBT && !ackPrev) begin
      if (expQ.size() == 0) begin
        checkOutput("ack_with_empty_queue", {31'b0, ACK_ADD_SUBT}, 32'd0);
      end else begin
        exp34 = expQ.pop_front();
        checkOutput("result",    Data_Result,           exp34[31:0]);
        checkOutput("overflow",  {31'b0, Overflow},     {31'b0, exp34[33]});
        checkOutput("underflow", {31'b0, Underflow},    {31'b0, exp34[32]});
      end
    end
    ackPrev = ACK_ADD_SUBT;
  end

  // Issues one operation and waits for its acknowledge; extraPulse>0 re-pulses Begin_SUM in that cycle.
  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic op, input int extraPulse);
    int cyc;
    expQ.push_back(refModel(x, y, op));
    @(negedge CLK);
    Data_X    = x;
    Data_Y    = y;
    ADD_SUBT  = op;
    Begin_SUM = 1'b1;
    @(posedge CLK);
    cyc = 1;
    @(negedge CLK);
    Begin_SUM = 1'b0;
    Data_X    = $urandom;
    Data_Y    = $urandom;
    ADD_SUBT  = 1'($urandom_range(0, 1));
    checkOutput("ack_drop", {31'b0, ACK_ADD_SUBT}, 32'd0);
    while (!ACK_ADD_SUBT && cyc < 20) begin
      if (cyc == extraPulse) Begin_SUM = 1'b1;
      @(posedge CLK);
      cyc++;
      @(negedge CLK);
      Begin_SUM = 1'b0;
    end
    checkOutput("latency", 32'(cyc), 32'd6);
  endtask

  task automatic directedCase(input string name, input logic [31:0] x, input logic [31:0] y, input logic op,
                              input logic [31:0] expRes, input logic expOvf, input logic expUnf);
    applyStimulus(x, y, op, 0);
    checkOutput({name, "_result"},    Data_Result,        expRes);
    checkOutput({name, "_overflow"},  {31'b0, Overflow},  {31'b0, expOvf});
    checkOutput({name, "_underflow"}, {31'b0, Underflow}, {31'b0, expUnf});
  endtask

  initial begin
    logic [31:0] x, y;
    logic        op;
    int          mode, e;

    RST_N     = 1'b0;
    Begin_SUM = 1'b0;
    ADD_SUBT  = 1'b0;
    Data_X    = '0;
    Data_Y    = '0;
    repeat (2) @(negedge CLK);
    checkOutput("reset_ack",       {31'b0, ACK_ADD_SUBT}, 32'd0);
    checkOutput("reset_result",    Data_Result,           32'd0);
    checkOutput("reset_overflow",  {31'b0, Overflow},     32'd0);
    checkOutput("reset_underflow", {31'b0, Underflow},    32'd0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    directedCase("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    checkOutput("ack_held",    {31'b0, ACK_ADD_SUBT}, 32'd1);
    checkOutput("result_held", Data_Result,           32'h40000000);

    directedCase("three_minus_one", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0);
    directedCase("one_minus_one",   32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0);
    directedCase("tie_even",        32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
    directedCase("above_tie",       32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 1'b0, 1'b0);
    directedCase("overflow",        32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0);
    directedCase("underflow",       32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b1);
    directedCase("inf_minus_inf",   32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b0);
    directedCase("nan_input",       32'h3F800000, 32'h7F800123, 1'b0, 32'h7FC00000, 1'b0, 1'b0);
    directedCase("inf_plus_finite", 32'hFF800000, 32'h42C80000, 1'b0, 32'hFF800000, 1'b0, 1'b0);
    directedCase("x_plus_zero",     32'hC0490FDB, 32'h00000000, 1'b0, 32'hC0490FDB, 1'b0, 1'b0);
    directedCase("zero_minus_zero", 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b0, 1'b0);

    // A Begin_SUM while busy must not restart or queue a second operation.
    applyStimulus(32'h3F800000, 32'h40000000, 1'b0, 3);
    checkOutput("ignored_pulse_result", Data_Result, 32'h40400000);
    repeat (8) @(negedge CLK);
    checkOutput("ignored_pulse_single_ack", {31'b0, ACK_ADD_SUBT}, 32'd1);

    // Reset in cycle 4 aborts the operation with no acknowledge.
    @(negedge CLK);
    Data_X    = 32'h40A00000;
    Data_Y    = 32'h3F800000;
    ADD_SUBT  = 1'b0;
    Begin_SUM = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Begin_SUM = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    checkOutput("abort_ack",       {31'b0, ACK_ADD_SUBT}, 32'd0);
    checkOutput("abort_result",    Data_Result,           32'd0);
    checkOutput("abort_overflow",  {31'b0, Overflow},     32'd0);
    checkOutput("abort_underflow", {31'b0, Underflow},    32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (12) @(negedge CLK);
    checkOutput("abort_no_ack", {31'b0, ACK_ADD_SUBT}, 32'd0);

    directedCase("after_abort", 32'h40A00000, 32'h3F800000, 1'b0, 32'h40C00000, 1'b0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      x    = $urandom;
      mode = int'($urandom_range(0, 9));
      case (mode)
        0: y = $urandom;
        1, 2, 3, 4, 5: begin
          e = int'(x[30:23]) + int'($urandom_range(0, 50)) - 25;
          if (e < 1) e = 1;
          if (e > 254) e = 254;
          y = {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
        end
        6: y = x ^ 32'($urandom_range(0, 7));
        7: begin
          x[30:23] = 8'($urandom_range(250, 254));
          y = {1'($urandom_range(0, 1)), 8'($urandom_range(250, 254)), 23'($urandom)};
        end
        8: begin
          x[30:23] = 8'($urandom_range(1, 3));
          y = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 3)), 23'($urandom)};
        end
        default: begin
          y = $urandom;
          if ($urandom_range(0, 1) == 1) y[30:23] = 8'hFF;
          else x[30:23] = 8'h00;
        end
      endcase
      op = 1'($urandom_range(0, 1));
      applyStimulus(x, y, op, 0);
    end

    repeat (3) @(negedge CLK);
    checkOutput("pending_results", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_add_subt_seq.md
Name: fp_add_subt_seq

Overview:
Multi-cycle IEEE-754 single-precision adder/subtractor. It is the responder side of the add/subtract start/acknowledge handshake used by the CORDIC/LN control FSMs. It accepts one operation per Begin_SUM pulse and returns a registered result with a held ACK_ADD_SUBT. Latency is fixed, and the unit is not pipelined: one operation is in flight at a time.

Parameters:
W, 32, total word width
EW, 8, exponent width
SW, 23, stored fraction width
BIAS, 127, exponent bias

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous, active-low reset
Begin_SUM  in  1  start pulse; sampled only in IDLE and DONE
ADD_SUBT  in  1  operation: 0 = X+Y, 1 = X-Y; sampled with Begin_SUM
Data_X  in  W  operand X; sampled with Begin_SUM
Data_Y  in  W  operand Y; sampled with Begin_SUM
ACK_ADD_SUBT  out  1  result valid; held high until next accepted Begin_SUM or reset
Data_Result  out  W  registered result; stable while ACK_ADD_SUBT=1
Overflow  out  1  result saturated to ±inf; valid with ACK
Underflow  out  1  result flushed to ±0; valid with ACK

Behaviour:
- Reset (RST_N=0, asynchronous):
  - state = IDLE.
  - ACK_ADD_SUBT, Data_Result, Overflow and Underflow = 0.
  - Internal operand registers = 0.
  - Reset mid-operation aborts the operation; no ACK is produced.
- States: IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE.
- IDLE:
  - Begin_SUM=1: latch X, Y, op → UNPACK.
  - Otherwise stay in IDLE.
- UNPACK:
  - Effective sign of Y = Y.sign XOR op.
  - Exponent field 0 → operand is zero; fraction ignored (denormals flushed).
  - Exponent field all-ones → special operand.
  - Mantissa = {hidden bit, fraction, 3'b000}, 27 bits: guard, round, sticky.
  - Swap operands so the larger magnitude is A. Comparison key is {exp, frac}.
- ALIGN:
  - d = expA - expB.
  - B mantissa is barrel-shifted right by d; shifted-out bits OR into sticky.
  - d ≥ 27 → B becomes sticky-only.
- ADD:
  - Same effective signs: 28-bit sum.
  - Otherwise A - B, which is never negative after the swap.
  - Result sign = sign of A.
- NORM:
  - Carry-out set: shift right 1 (sticky preserved), exp+1.
  - Else shift left by the leading-zero count from fp_lzc, exp - count.
  - Zero magnitude → +0 (sign forced positive).
- ROUND:
  - Round-to-nearest-even: increment when G & (R | S | lsb).
  - Mantissa overflow from rounding → exp+1.
  - Final exp ≥ 255 → ±inf (0x7F800000 | sign), Overflow=1.
  - Final exp ≤ 0 → ±0, Underflow=1.
  - Data_Result, flags and ACK register at the end of ROUND → DONE.
- DONE:
  - ACK_ADD_SUBT=1; outputs are held.
  - Begin_SUM=1: clear ACK and flags at the same edge, latch new operands → UNPACK.
- Latency: Begin_SUM high in cycle 0 → ACK_ADD_SUBT high from cycle 6. Back-to-back operations therefore cost 6 cycles each.
- Begin_SUM in UNPACK through ROUND is ignored; no queueing.
- Specials:
  - Any NaN input → 0x7FC00000.
  - inf - inf (effective) → 0x7FC00000.
  - inf ± finite → that inf.
  - Flags are 0 for all specials.
- Zero operands: x + 0 → x exactly. 0 - 0 → +0.

Decomposition:
- Package fp_add_subt_pkg: state encoding, EW/SW/BIAS, and the constants QNAN=0x7FC00000, PINF=0x7F800000 and the 27/28-bit internal mantissa widths.
- One sub-module, fp_lzc: combinational 28-bit leading-zero counter (5-bit output) used in NORM.
- Barrel shifters stay inline.

Test Plan:
- Basic add: 0x3F800000 + 0x3F800000, ADD_SUBT=0; Begin_SUM at cycle 0 → ACK at cycle 6, Data_Result=0x40000000, flags 0; ACK held until the next Begin_SUM.
- Subtraction: 0x40400000 - 0x3F800000 → 0x40000000. 0x3F800000 - 0x3F800000 → 0x00000000 with sign bit 0.
- Rounding:
  - 0x3F800000 + 0x33800000 (exact tie) → 0x3F800000.
  - 0x3F800000 + 0x33800001 → 0x3F800001.
- Overflow: 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, Overflow=1.
- Underflow and specials:
  - 0x00800001 - 0x00800000 → 0x00000000, Underflow=1.
  - 0x7F800000 - 0x7F800000 → 0x7FC00000.
- Handshake and reset:
  - Begin_SUM pulsed again in cycle 3 → ignored; single ACK at cycle 6 with the first result.
  - Begin_SUM in DONE → ACK drops on the next cycle; new result 6 cycles later.
  - RST_N low in cycle 4 → all outputs 0 immediately, IDLE, no ACK afterward.
